// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the response signals and the memory
// side of the two-port memory arbiter.
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output ack0, ack1, err0, err1, rdata, busy,
               mem_write_enable, mem_read_enable, mem_addr, mem_data_in
    );

    // Requester view
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata, busy
    );

    // Memory view
    modport memory (
        input  mem_write_enable, mem_read_enable, mem_addr, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter. One transaction in flight at a time:
// IDLE latches a winner, ACCESS strobes the memory for one cycle, CAPTURE
// registers read data, RESP pulses the winner's ack. A word at 16'hFFFF would
// straddle the top of memory and is rejected without touching the memory.
module mem_arbiter (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state_q;
    logic        last_q;      // port granted most recently
    logic        port_q;      // port owning the current transaction
    logic        we_q;
    logic        reject_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        err0_q;
    logic        err1_q;
    logic        busy_q;
    logic        wr_en_q;
    logic        rd_en_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_data_q;
    logic [15:0] rdata_q;

    logic        req_any_s;
    logic        grant_s;
    logic        sel_we_s;
    logic [15:0] sel_addr_s;
    logic [15:0] sel_wdata_s;

    // Round-robin winner and a mux of the winner's request fields
    always_comb begin
        req_any_s = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_s = ~last_q;
        end else if (bus.req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_we_s    = bus.we1;
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
        end else begin
            sel_we_s    = bus.we0;
            sel_addr_s  = bus.addr0;
            sel_wdata_s = bus.wdata0;
        end
    end

    // Transaction FSM with all outputs registered; pulses default low each cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            reject_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_data_q <= 16'h0000;
            rdata_q    <= 16'h0000;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any_s) begin
                        port_q     <= grant_s;
                        last_q     <= grant_s;
                        we_q       <= sel_we_s;
                        mem_addr_q <= sel_addr_s;
                        mem_data_q <= sel_wdata_s;
                        if (sel_addr_s == 16'hFFFF) begin
                            reject_q <= 1'b1;
                        end else begin
                            reject_q <= 1'b0;
                            wr_en_q  <= sel_we_s;
                            rd_en_q  <= ~sel_we_s;
                        end
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    busy_q <= 1'b1;
                    if (reject_q || we_q) begin
                        ack0_q  <= ~port_q;
                        ack1_q  <= port_q;
                        err0_q  <= reject_q & ~port_q;
                        err1_q  <= reject_q & port_q;
                        state_q <= RESP;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    busy_q  <= 1'b1;
                    rdata_q <= bus.mem_data_out;
                    ack0_q  <= ~port_q;
                    ack1_q  <= port_q;
                    state_q <= RESP;
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0             = ack0_q;
    assign bus.ack1             = ack1_q;
    assign bus.err0             = err0_q;
    assign bus.err1             = err1_q;
    assign bus.busy             = busy_q;
    assign bus.rdata            = rdata_q;
    assign bus.mem_write_enable = wr_en_q;
    assign bus.mem_read_enable  = rd_en_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_data_in      = mem_data_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; reset=0 SHALL immediately force the reset state.
REQ-003 req0, req1  in  1 each  access request from port 0 (data) and port 1 (fetch); held high until ack.
REQ-004 we0, we1  in  1 each  1=write, 0=read; valid while the matching req is high.
REQ-005 addr0, addr1  in  16 each  byte address of a 16-bit little-endian word.
REQ-006 wdata0, wdata1  in  16 each  write data; valid while the matching req is high.
REQ-007 ack0, ack1  out  1 each  one-cycle completion pulse for the port.
REQ-008 err0, err1  out  1 each  one-cycle pulse with ack when the request was rejected.
REQ-009 rdata  out  16  read result; valid in the cycle ack0 or ack1 is high for a read.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 mem_write_enable, mem_read_enable  out  1 each  memory strobes.
REQ-012 mem_addr, mem_data_in  out  16 each  memory address and write data.
REQ-013 mem_data_out  in  16  registered memory read data, valid one cycle after the read strobe edge.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, CAPTURE and RESP; only one transaction SHALL be in flight.
REQ-015 IDLE with any req high: winner selected, its we/addr/wdata latched, next state ACCESS.
REQ-016 Arbitration SHALL be round-robin: when both req are high, the port not granted last wins; a single requester always wins.
REQ-017 Last-grant pointer SHALL update only when a winner is latched; after reset it SHALL point at port 1, so port 0 wins the first conflict.
REQ-018 ACCESS: exactly one of mem_read_enable/mem_write_enable high for exactly this one cycle, with mem_addr/mem_data_in = latched values.
REQ-019 Outside ACCESS, both strobes SHALL be 0; mem_addr/mem_data_in SHALL hold the latched values.
REQ-020 Write: ACCESS -> RESP; read: ACCESS -> CAPTURE -> RESP.
REQ-021 CAPTURE: mem_data_out SHALL be registered into rdata at the end of the cycle; rdata SHALL hold until the next read capture.
REQ-022 RESP: the granted port's ack SHALL be high for this cycle only; next state IDLE.
REQ-023 Latency from the first IDLE cycle with req high to ack SHALL be 3 cycles for a write and 4 cycles for a read.
REQ-024 A requester holding req in the cycle after ack SHALL be treated as a new transaction, re-arbitrated in IDLE.
REQ-025 A latched address of 16'hFFFF (word crosses the top of memory) SHALL be rejected: no memory strobe, ACCESS -> RESP, ack and err pulse together, rdata unchanged.
REQ-026 Deasserting req after latching SHALL NOT abort the transaction; ack still pulses.
REQ-027 Changes to addr/wdata/we after latching SHALL have no effect on the current transaction.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-029 reset=0: state IDLE; ack0/1, err0/1, busy, mem_write_enable and mem_read_enable SHALL be 0 immediately, without waiting for clk.
REQ-030 reset=0: rdata, mem_addr and mem_data_in = 16'h0000; last-grant pointer = port 1.
REQ-031 reset asserted mid-transaction: the transaction SHALL be dropped with no ack; after release, the arbiter SHALL resume from IDLE.

Verification
REQ-032 req0 write, addr0=16'h0010, wdata0=16'hBEEF -> mem_write_enable for one cycle with addr 16'h0010 and data 16'hBEEF; ack0 3 cycles after req.
REQ-033 Then req1 read at 16'h0010 -> mem_read_enable for one cycle; ack1 4 cycles after req with rdata=16'hBEEF.
REQ-034 req0 and req1 both high from reset, held continuously -> grants in order 0,1,0,1; no double ack.
REQ-035 req0 read at 16'hFFFF -> no memory strobe; ack0 and err0 together 3 cycles after req; rdata unchanged.
REQ-036 reset pulled low during CAPTURE -> strobes and ack stay 0 and busy drops immediately; next req0 completes normally.
